// File: rtl/dropout_pkg.sv
// Shared constants, FSM state type and LFSR step function for the dropout mask generator.
// Latency: n/a (package only).
// Backpressure: n/a.
package dropout_pkg;

    localparam int              LFSR_W       = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Right-shifting Galois step: feedback is the bit shifted out.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/dropout_lfsr16.sv
// 16-bit Galois LFSR with seed load; a zero seed falls back to SEED so the register never locks up.
// Latency: state updates one cycle after load/advance.
// Backpressure: none; advances only when told to.
module dropout_lfsr16
    import dropout_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              advance,
    output logic [LFSR_W-1:0] state
);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SEED;
        end else if (load) begin
            state <= (load_val == '0) ? SEED : load_val;
        end else if (advance) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/dropout_mask_gen.sv
// Dropout keep/drop mask generator: N LFSR-derived bits per mask; DROPOUT_MASK_STATS_EN adds drop_count.
// Latency: N+1 cycles from enable to first mask_valid; one mask per N+1 cycles when unstalled.
// Backpressure: mask and LFSR hold in HOLD until mask_valid && mask_ready.
module dropout_mask_gen
    import dropout_pkg::*;
#(
    parameter int          N    = 8,
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [7:0]   rate,
    input  logic         seed_load,
    input  logic [15:0]  seed_in,
    output logic [N-1:0] mask,
    output logic         mask_valid,
    input  logic         mask_ready
`ifdef DROPOUT_MASK_STATS_EN
    ,
    output logic [15:0]  drop_count
`endif
);

    localparam int CW = $clog2(N + 1);

    state_t         state, state_nxt;
    logic [CW-1:0]  bit_cnt;
    logic [N-1:0]   mask_q;
    logic [N:0]     mask_shift;
    logic [15:0]    lfsr;
    logic           fill_en;
    logic           xfer;
    logic           last_bit;
    logic           new_bit;

    assign fill_en    = (state == FILL) && enable;
    assign xfer       = (state == HOLD) && mask_ready;
    assign last_bit   = (bit_cnt == CW'(N - 1));
    assign new_bit    = (lfsr[7:0] >= rate);
    assign mask_shift = {new_bit, mask_q};

    dropout_lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (seed_load),
        .load_val (seed_in),
        .advance  (fill_en && !seed_load),
        .state    (lfsr)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = FILL;
            FILL:    if (enable && last_bit) state_nxt = HOLD;
            HOLD:    if (mask_ready) state_nxt = enable ? FILL : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (seed_load) begin
            state_nxt = enable ? FILL : IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            mask_q  <= '0;
        end else begin
            state <= state_nxt;
            if (seed_load) begin
                bit_cnt <= '0;
                mask_q  <= '0;
            end else if (fill_en) begin
                // New bit enters at the MSB so the first generated bit lands in bit 0.
                mask_q  <= mask_shift[N:1];
                bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
            end
        end
    end

    assign mask       = mask_q;
    assign mask_valid = (state == HOLD);

`ifdef DROPOUT_MASK_STATS_EN
    logic [15:0]   drop_cnt_q;
    logic [CW-1:0] zero_bits;
    logic [16:0]   drop_sum;

    always_comb begin
        zero_bits = '0;
        for (int i = 0; i < N; i++) begin
            zero_bits = zero_bits + CW'(~mask_q[i]);
        end
        drop_sum = {1'b0, drop_cnt_q} + 17'(zero_bits);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else if (xfer && !seed_load) begin
            drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_dropout_mask_gen.sv
// Directed bench for dropout_mask_gen: latency, masks against a reference LFSR, stalls, seeding, reset.
// Latency: n/a.
// Backpressure: exercised by holding mask_ready low.
module tb_dropout_mask_gen;
    import dropout_pkg::*;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [7:0]   rate;
    logic         seed_load;
    logic [15:0]  seed_in;
    logic [N-1:0] mask;
    logic         mask_valid;
    logic         mask_ready;
`ifdef DROPOUT_MASK_STATS_EN
    logic [15:0]  drop_count;
`endif

    int          total = 0;
    int          bad   = 0;
    logic [15:0] mlfsr;

    always #5 clk = ~clk;

    dropout_mask_gen #(.N(N)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .rate       (rate),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .mask       (mask),
        .mask_valid (mask_valid),
        .mask_ready (mask_ready)
`ifdef DROPOUT_MASK_STATS_EN
        ,
        .drop_count (drop_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input int bound, output int cycles);
        cycles = 0;
        while (mask_valid !== 1'b1 && cycles < bound) begin
            @(negedge clk);
            cycles++;
        end
        chk("valid_within_bound", 32'(mask_valid), 32'd1);
    endtask

    function automatic logic [15:0] nx(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic model_mask(input logic [7:0] r, output logic [N-1:0] m);
        for (int i = 0; i < N; i++) begin
            m[i]  = (mlfsr[7:0] >= r);
            mlfsr = nx(mlfsr);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        enable    = 1'b0;
        seed_load = 1'b0;
        step(1);
        reset     = 1'b0;
    endtask

    initial begin
        int           c;
        int           zeros;
        logic [N-1:0] em;
        logic [15:0]  tmp;

        reset = 1'b1; enable = 1'b0; seed_load = 1'b0; mask_ready = 1'b0;
        rate = 8'd0; seed_in = 16'h0;
        step(2);
        reset = 1'b0;

        // Reset state
        chk("rst_mask", 32'(mask), 32'h0);
        chk("rst_valid", 32'(mask_valid), 32'd0);
        chk("rst_state", 32'(u_dut.state), 32'(IDLE));
        chk("rst_lfsr", 32'(u_dut.u_lfsr.state), 32'hACE1);

        // rate=0: first valid on the 9th edge after enable, all-ones masks, period 9
        rate = 8'd0; mask_ready = 1'b1; enable = 1'b1;
        wait_valid(20, c);
        chk("first_latency", 32'(c), 32'd9);
        chk("r0_mask", 32'(mask), 32'hFF);
        for (int k = 0; k < 4; k++) begin
            step(1);
            wait_valid(20, c);
            chk("r0_period", 32'(c + 1), 32'd9);
            chk("r0_mask", 32'(mask), 32'hFF);
        end

        // rate=255, 1000 masks against the reference LFSR
        do_reset();
        mlfsr = 16'hACE1; rate = 8'd255; mask_ready = 1'b1; enable = 1'b1;
        zeros = 0;
        for (int k = 0; k < 1000; k++) begin
            wait_valid(20, c);
            model_mask(8'd255, em);
            chk("r255_mask", 32'(mask), 32'(em));
            for (int i = 0; i < N; i++) if (!mask[i]) zeros++;
            step(1);
        end
        chk("r255_zero_99pct", 32'(zeros >= 7920), 32'd1);

        // Backpressure: 20 stalled cycles in HOLD, enable dropped halfway
        do_reset();
        mlfsr = 16'hACE1; rate = 8'd128; mask_ready = 1'b0; enable = 1'b1;
        wait_valid(20, c);
        model_mask(8'd128, em);
        chk("bp_mask", 32'(mask), 32'(em));
        chk("bp_lfsr", 32'(u_dut.u_lfsr.state), 32'(mlfsr));
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (k == 10) enable = 1'b0;
            chk("bp_hold_valid", 32'(mask_valid), 32'd1);
            chk("bp_hold_mask", 32'(mask), 32'(em));
            chk("bp_hold_lfsr", 32'(u_dut.u_lfsr.state), 32'(mlfsr));
        end
        enable = 1'b1; mask_ready = 1'b1;
        step(1);
        mask_ready = 1'b0;
        chk("bp_one_xfer_valid", 32'(mask_valid), 32'd0);
        wait_valid(20, c);
        chk("bp_refill_cycles", 32'(c), 32'd8);
        model_mask(8'd128, em);
        chk("bp_next_mask", 32'(mask), 32'(em));

        // enable low in FILL freezes LFSR, counter and mask
        do_reset();
        rate = 8'd0; mask_ready = 1'b1; enable = 1'b1;
        step(3);
        enable = 1'b0;
        step(3);
        tmp = nx(nx(16'hACE1));
        chk("frz_state", 32'(u_dut.state), 32'(FILL));
        chk("frz_mask", 32'(mask), 32'hC0);
        chk("frz_lfsr", 32'(u_dut.u_lfsr.state), 32'(tmp));
        enable = 1'b1;
        wait_valid(20, c);
        chk("frz_remaining", 32'(c), 32'd6);
        chk("frz_final_mask", 32'(mask), 32'hFF);

        // seed_load of zero mid-HOLD falls back to SEED and withdraws valid
        mask_ready = 1'b0; enable = 1'b0; seed_in = 16'h0000; seed_load = 1'b1;
        step(1);
        seed_load = 1'b0;
        chk("seed0_valid", 32'(mask_valid), 32'd0);
        chk("seed0_lfsr", 32'(u_dut.u_lfsr.state), 32'hACE1);
        chk("seed0_mask", 32'(mask), 32'h0);
        chk("seed0_state", 32'(u_dut.state), 32'(IDLE));

        // Two runs seeded 16'h1234 give the same model sequence
        for (int run = 0; run < 2; run++) begin
            rate = 8'd100; mask_ready = 1'b1; enable = 1'b1;
            seed_in = 16'h1234; seed_load = 1'b1;
            step(1);
            seed_load = 1'b0;
            chk("seed_lfsr", 32'(u_dut.u_lfsr.state), 32'h1234);
            chk("seed_state", 32'(u_dut.state), 32'(FILL));
            mlfsr = 16'h1234;
            for (int k = 0; k < 3; k++) begin
                wait_valid(20, c);
                model_mask(8'd100, em);
                chk("seed_mask", 32'(mask), 32'(em));
                step(1);
            end
        end

        // Reset on the 4th FILL cycle
        do_reset();
        rate = 8'd0; mask_ready = 1'b1; enable = 1'b1;
        step(4);
        chk("mid_fill_mask", 32'(mask), 32'hE0);
        chk("mid_fill_state", 32'(u_dut.state), 32'(FILL));
        reset = 1'b1; enable = 1'b0;
        step(1);
        reset = 1'b0;
        chk("rst_fill_mask", 32'(mask), 32'h0);
        chk("rst_fill_valid", 32'(mask_valid), 32'd0);
        chk("rst_fill_state", 32'(u_dut.state), 32'(IDLE));
        chk("rst_fill_lfsr", 32'(u_dut.u_lfsr.state), 32'hACE1);

`ifdef DROPOUT_MASK_STATS_EN
        begin
            int drops;
            do_reset();
            chk("stats_reset", 32'(drop_count), 32'd0);
            mlfsr = 16'hACE1; rate = 8'd128; mask_ready = 1'b1; enable = 1'b1;
            drops = 0;
            for (int k = 0; k < 10; k++) begin
                wait_valid(20, c);
                model_mask(8'd128, em);
                chk("stats_mask", 32'(mask), 32'(em));
                for (int i = 0; i < N; i++) if (!em[i]) drops++;
                step(1);
            end
            chk("stats_count", 32'(drop_count), 32'(drops));
            force u_dut.drop_cnt_q = 16'hFFF0;
            #1;
            release u_dut.drop_cnt_q;
            rate = 8'd255;
            for (int k = 0; k < 3; k++) begin
                wait_valid(20, c);
                step(1);
            end
            chk("stats_saturate", 32'(drop_count), 32'hFFFF);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dropout_mask_gen.md
DROPOUT_MASK_GEN -- requirements
Module: dropout_mask_gen

Interface
REQ-001 The block SHALL have parameter N, default 8: mask width in bits, matching the dropout datapath width.
REQ-002 The block SHALL have parameter SEED, default 16'hACE1: LFSR value after reset.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port enable, input, 1: high = generate masks; low = pause.
REQ-006 Port rate, input, 8: drop threshold; a bit is dropped when the LFSR low byte is < rate.
REQ-007 Port seed_load, input, 1: a one-cycle pulse that loads seed_in into the LFSR.
REQ-008 Port seed_in, input, 16: seed value.
REQ-009 Port mask, output, N: 1 = keep, 0 = drop; bit i is the i-th generated bit.
REQ-010 Port mask_valid, output, 1: mask is held stable and offered downstream.
REQ-011 Port mask_ready, input, 1: downstream accepts; a transfer occurs when mask_valid and mask_ready are both high.

Function
REQ-012 The LFSR SHALL be 16-bit Galois, taps 16'hB400, shifted right; it advances exactly once per FILL cycle with enable high.
REQ-013 Each FILL cycle SHALL compute bit = (lfsr[7:0] >= rate) from the pre-advance LFSR value and the current rate, shifted into the mask at the MSB.
REQ-014 The FSM SHALL have states IDLE, FILL and HOLD.
- IDLE->FILL when enable is high.
- FILL->HOLD after N enabled FILL cycles, tracked by a bit counter of width clog2(N+1).
- HOLD->FILL on transfer if enable is high, else HOLD->IDLE on transfer.
REQ-015 mask_valid SHALL be high only in HOLD; mask and the LFSR SHALL be frozen while in HOLD.
REQ-016 With enable held high and mask_ready high, the first mask_valid SHALL occur N+1 cycles after enable is first sampled high; steady throughput is one mask per N+1 cycles.
REQ-017 enable low in FILL SHALL freeze the LFSR, counter and mask without leaving FILL.
REQ-018 enable low in HOLD SHALL NOT withdraw mask_valid.
REQ-019 seed_load SHALL load the LFSR with seed_in, or with SEED if seed_in is zero (lockup avoidance), and clear the counter and mask.
- The FSM then goes to FILL if enable is high, else IDLE.
- mask_valid drops the next cycle, even mid-HOLD.
REQ-020 Priority SHALL be reset > seed_load > transfer/fill.
REQ-021 rate=0 SHALL yield all-ones masks; rate=255 SHALL drop a bit unless the LFSR low byte equals 8'hFF.

Reset
REQ-022 Reset SHALL force the LFSR to SEED, the FSM to IDLE, and the counter, mask and mask_valid to 0, effective the cycle after assertion, including mid-FILL or mid-HOLD.

Configuration
REQ-023 Macro DROPOUT_MASK_STATS_EN, when defined, SHALL add output drop_count[15:0]: the count of zero bits in transferred masks, saturating at 16'hFFFF, cleared by reset only.
REQ-024 Without DROPOUT_MASK_STATS_EN, the port and its counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-025 Package dropout_pkg SHALL hold the LFSR width (16), tap constant 16'hB400, default seed 16'hACE1, and the FSM state enum.
REQ-026 The LFSR SHALL be the sub-module dropout_lfsr16, with ports clk, reset, load, load_val, advance and state.

Verification
REQ-027 Reset, then enable=1, rate=0, mask_ready=1: mask_valid first high 9 cycles after enable; every mask is 8'hFF.
REQ-028 rate=255, default seed, 1000 masks: each bit matches the reference LFSR model; at least 99% of bits are 0.
REQ-029 mask_ready=0 for 20 cycles in HOLD: mask_valid stays 1 and mask and LFSR do not change; raising ready transfers exactly one mask.
REQ-030 seed_load with seed_in=0: LFSR reads 16'hACE1; two runs seeded 16'h1234 produce identical mask sequences.
REQ-031 Reset asserted on the 4th FILL cycle: next cycle mask=0, mask_valid=0, state IDLE, LFSR=SEED.
REQ-032 With DROPOUT_MASK_STATS_EN and rate=128, drop_count equals the total zero bits of transferred masks; preloading near saturation holds the count at 16'hFFFF.
